// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with runtime parity/stop selection
// Optional clear-to-send flow control is enabled by defining UART_TX_CTS_EN.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_stb,
  output logic                  o_ready,
  output logic [LEVEL_W-1:0]    o_fifo_level,
  output logic                  o_busy,
  output logic                  o_uart_tx,
  input  logic [15:0]           i_baudrate_prescaler,
  input  logic [1:0]            i_parity,
  input  logic                  i_two_stop
`ifdef UART_TX_CTS_EN
  ,
  input  logic                  i_cts_n
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state, state_nxt;
  logic                  tx, tx_nxt;
  logic                  busy, busy_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [15:0]           baud_cnt, baud_nxt;
  logic [15:0]           prescale, prescale_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic                  stop_cnt, stop_nxt;
  logic                  par_en, par_en_nxt;
  logic                  par_bit, par_bit_nxt;
  logic                  two_stop, two_stop_nxt;
  logic                  launch;
  logic                  clear_to_send;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LEVEL_W-1:0]    count, count_nxt;
  logic                  full, push, pop, can_start, bit_done;
  logic [DATA_WIDTH-1:0] head;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cts_sync <= 2'b11;
    else         cts_sync <= {cts_sync[0], i_cts_n};
  end
  assign clear_to_send = ~cts_sync[1];
`else
  assign clear_to_send = 1'b1;
`endif

  assign full         = (count == LEVEL_W'(FIFO_DEPTH));
  assign o_ready      = ~full;
  assign push         = i_data_stb & ~full;
  assign pop          = launch;
  assign head         = mem[rd_ptr];
  assign o_fifo_level = count;
  assign o_busy       = busy;
  assign o_uart_tx    = tx;
  assign can_start    = (count != '0) && clear_to_send;
  assign bit_done     = (baud_cnt == 16'd0);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + LEVEL_W'(1);
    else if (!push && pop) count_nxt = count - LEVEL_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      shreg    <= '0;
      baud_cnt <= '0;
      prescale <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      two_stop <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx       <= tx_nxt;
      busy     <= busy_nxt;
      shreg    <= shreg_nxt;
      baud_cnt <= baud_nxt;
      prescale <= prescale_nxt;
      bit_cnt  <= bit_nxt;
      stop_cnt <= stop_nxt;
      par_en   <= par_en_nxt;
      par_bit  <= par_bit_nxt;
      two_stop <= two_stop_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tx_nxt       = tx;
    shreg_nxt    = shreg;
    baud_nxt     = baud_cnt;
    bit_nxt      = bit_cnt;
    stop_nxt     = stop_cnt;
    prescale_nxt = prescale;
    par_en_nxt   = par_en;
    par_bit_nxt  = par_bit;
    two_stop_nxt = two_stop;
    launch       = 1'b0;

    if (state != S_IDLE) baud_nxt = bit_done ? prescale : baud_cnt - 16'd1;

    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        launch = can_start;
      end
      S_START: if (bit_done) begin
        state_nxt = S_DATA;
        tx_nxt    = shreg[0];
        shreg_nxt = shreg >> 1;
        bit_nxt   = '0;
      end
      S_DATA: if (bit_done) begin
        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
          if (par_en) begin
            state_nxt = S_PARITY;
            tx_nxt    = par_bit;
          end else begin
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
            stop_nxt  = two_stop;
          end
        end else begin
          tx_nxt    = shreg[0];
          shreg_nxt = shreg >> 1;
          bit_nxt   = bit_cnt + BW'(1);
        end
      end
      S_PARITY: if (bit_done) begin
        state_nxt = S_STOP;
        tx_nxt    = 1'b1;
        stop_nxt  = two_stop;
      end
      S_STOP: if (bit_done) begin
        if (stop_cnt)       stop_nxt = 1'b0;
        else if (can_start) launch   = 1'b1;
        else begin
          state_nxt = S_IDLE;
          tx_nxt    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Frame start: pop the head word and freeze this frame's timing and format.
    if (launch) begin
      state_nxt    = S_START;
      tx_nxt       = 1'b0;
      shreg_nxt    = head;
      prescale_nxt = i_baudrate_prescaler;
      baud_nxt     = i_baudrate_prescaler;
      par_en_nxt   = i_parity[0] ^ i_parity[1];
      par_bit_nxt  = (^head) ^ (i_parity == 2'b01);
      two_stop_nxt = i_two_stop;
    end
  end

  assign busy_nxt = (state_nxt != S_IDLE) || (count_nxt != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed-vector bench for uart_tx_fifo
// Builds with or without UART_TX_CTS_EN; the CTS scenario runs only when it is defined.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        stb;
  logic        ready;
  logic [2:0]  level;
  logic        busy;
  logic        tx;
  logic [15:0] presc;
  logic [1:0]  parity;
  logic        two_stop;
`ifdef UART_TX_CTS_EN
  logic        cts_n;
`endif

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  logic trace [0:4095];

  uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_data(data),
    .i_data_stb(stb),
    .o_ready(ready),
    .o_fifo_level(level),
    .o_busy(busy),
    .o_uart_tx(tx),
    .i_baudrate_prescaler(presc),
    .i_parity(parity),
    .i_two_stop(two_stop)
`ifdef UART_TX_CTS_EN
    ,
    .i_cts_n(cts_n)
`endif
  );

  always #5 clk = ~clk;

  // trace[k] holds the line level during the clock interval numbered k.
  always @(negedge clk) begin
    trace[cyc % 4096] <= tx;
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    data = d;
    stb  = 1'b1;
    tick_n(1);
    stb  = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input int start, input logic [7:0] d,
                              input logic [1:0] par, input logic two, input int p);
    logic [15:0] bits;
    int nb;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    nb = 9;
    if (par == 2'b01 || par == 2'b10) begin
      bits[nb] = (^d) ^ (par == 2'b01);
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
    if (two) begin
      bits[nb] = 1'b1;
      nb++;
    end
    for (int k = 0; k < nb; k++) begin
      logic [31:0] got, exp;
      got = '0;
      exp = '0;
      for (int j = 0; j <= p; j++) begin
        got[j] = trace[(start + k * (p + 1) + j) % 4096];
        exp[j] = bits[k];
      end
      check($sformatf("%s bit%0d", tag, k), got, exp);
    end
  endtask

  task automatic single_frame(input string tag, input logic [7:0] d, input logic [1:0] par,
                              input logic two, input int p, input int n);
    int start;
    parity   = par;
    two_stop = two;
    presc    = 16'(p);
    push(d);
    check({tag, " busy@accept"}, busy, 1);
    check({tag, " level@accept"}, level, 1);
    check({tag, " tx@accept"}, tx, 1);
    start = cyc + 1;
    tick_n(1);
    check({tag, " tx low E+1"}, tx, 0);
    check({tag, " level popped"}, level, 0);
    tick_n(n - 1);
    check({tag, " busy last clk"}, busy, 1);
    tick_n(1);
    check({tag, " busy end"}, busy, 0);
    check({tag, " tx idle"}, tx, 1);
    expect_frame(tag, start, d, par, two, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start, mark, zeros;
    rst = 1'b1; stb = 1'b0; data = '0; presc = 16'd3; parity = 2'b00; two_stop = 1'b0;
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif
    #2;
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset ready", ready, 1);
    check("reset level", level, 0);
    tick_n(2);
    rst = 1'b0;
    tick_n(2);

    single_frame("a5 plain", 8'hA5, 2'b00, 1'b0, 3, 40);
    tick_n(2);
    single_frame("a5 even", 8'hA5, 2'b10, 1'b0, 3, 44);
    tick_n(2);
    single_frame("a5 odd 2stop", 8'hA5, 2'b01, 1'b1, 3, 48);
    tick_n(2);
    single_frame("3c reserved par", 8'h3C, 2'b11, 1'b0, 3, 40);
    tick_n(2);

    // Overfill: six strobes on consecutive edges, the sixth must be dropped.
    parity = 2'b00; two_stop = 1'b0; presc = 16'd3;
    data = 8'd0; stb = 1'b1;
    tick_n(1);
    start = cyc + 1;
    check("fill level E0", level, 1);
    for (int i = 1; i <= 5; i++) begin
      data = 8'(i);
      tick_n(1);
      if (i == 3) check("fill ready E3", ready, 1);
      if (i == 4) begin
        check("fill ready E4", ready, 0);
        check("fill level E4", level, 4);
      end
    end
    stb = 1'b0;
    check("fill level E5", level, 4);
    check("fill ready E5", ready, 0);
    tick_n(195);
    check("fill busy last clk", busy, 1);
    tick_n(1);
    check("fill busy end", busy, 0);
    check("fill level end", level, 0);
    for (int w = 0; w < 5; w++)
      expect_frame($sformatf("fill w%0d", w), start + w * 40, 8'(w), 2'b00, 1'b0, 3);
    tick_n(2);

    // Prescaler 0, then retimed to 7 while the first frame is on the line.
    presc = 16'd0;
    push(8'h5A);
    start = cyc + 1;
    push(8'h81);
    tick_n(1);
    presc = 16'd7;
    tick_n(88);
    check("presc busy last clk", busy, 1);
    tick_n(1);
    check("presc busy end", busy, 0);
    expect_frame("presc0", start, 8'h5A, 2'b00, 1'b0, 0);
    expect_frame("presc7", start + 10, 8'h81, 2'b00, 1'b0, 7);
    tick_n(2);

    // Async reset during data bit 3 with two words still queued.
    presc = 16'd3;
    push(8'hF0);
    push(8'h11);
    push(8'h22);
    tick_n(16);
    check("pre-reset tx bit3", tx, 0);
    check("pre-reset level", level, 2);
    rst = 1'b1;
    #1;
    check("async reset tx", tx, 1);
    check("async reset busy", busy, 0);
    check("async reset level", level, 0);
    check("async reset ready", ready, 1);
    tick_n(2);
    rst = 1'b0;
    mark = cyc;
    tick_n(60);
    zeros = 0;
    for (int i = 0; i < 60; i++) if (trace[(mark + i) % 4096] !== 1'b1) zeros++;
    check("post-reset low clocks", zeros, 0);
    check("post-reset busy", busy, 0);

`ifdef UART_TX_CTS_EN
    begin
      int waited;
      cts_n = 1'b1;
      tick_n(2);
      push(8'h3C);
      tick_n(8);
      check("cts hold tx", tx, 1);
      check("cts hold busy", busy, 1);
      check("cts hold level", level, 1);
      cts_n = 1'b0;
      waited = 0;
      while (tx !== 1'b0 && waited < 6) begin
        tick_n(1);
        waited++;
      end
      check("cts start within 3", (waited >= 1 && waited <= 3), 1);
      start = cyc;
      tick_n(10);
      cts_n = 1'b1;
      tick_n(30);
      check("cts frame busy end", busy, 0);
      expect_frame("cts 3c", start, 8'h3C, 2'b00, 1'b0, 3);
      cts_n = 1'b0;
    end
`endif

    tick_n(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the team's single-word UART transmitter. It adds an internal FIFO, a valid/ready write handshake, runtime-selectable parity and 1 or 2 stop bits. Frames are sent back-to-back with no idle gap while data remains. It sits between a CPU/bus peripheral register block and the physical TX pin.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..16), sent LSB first
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2
LEVEL_W, $clog2(FIFO_DEPTH)+1, width of the level output (derived, not overridden)

Ports:
i_clk  input  1  single system clock
i_reset  input  1  asynchronous, active-high reset
i_data  input  DATA_WIDTH  word to enqueue
i_data_stb  input  1  write valid; word accepted on rising edge when i_data_stb && o_ready
o_ready  output  1  FIFO not full
o_fifo_level  output  LEVEL_W  number of words queued, excluding the frame in flight
o_busy  output  1  frame in flight or FIFO non-empty
o_uart_tx  output  1  serial line, idle high
i_baudrate_prescaler  input  16  clocks per bit minus 1; externally registered
i_parity  input  2  00 none, 01 odd, 10 even, 11 none (reserved)
i_two_stop  input  1  1 = two stop bits

Behaviour:
- Reset, async on i_reset high, applies immediately with no clock edge:
  - o_uart_tx=1, o_busy=0, o_ready=1, o_fifo_level=0
  - FIFO pointers cleared; FSM=IDLE
  - any frame in progress is abandoned and not resumed.
- FIFO: registered pointers and count.
  - Push when i_data_stb && o_ready.
  - Pop only by the FSM at frame start.
  - Push and pop in the same cycle leave the level unchanged.
  - o_ready is low whenever level==FIFO_DEPTH; a strobe while full is dropped silently.
  - Pointers wrap modulo FIFO_DEPTH.
- Bit timing: every serial bit lasts exactly i_baudrate_prescaler+1 clocks.
  - Prescaler value, i_parity and i_two_stop are latched at frame start.
  - Changes mid-frame affect only the next frame.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped when parity none) -> STOP -> IDLE or START.
  - IDLE: line high. If level!=0, pop a word, drive 0, enter START.
  - DATA: DATA_WIDTH bits, LSB first, driven from a shift register.
  - PARITY: even = XOR of data bits; odd = its inverse.
  - STOP: line high for 1 or 2 bit periods.
  - At the end of the last stop period: if level!=0, pop and go directly to START on that same edge (no idle gap); otherwise go to IDLE.
- Latency: a word accepted at edge E into an empty, idle block drives o_uart_tx low at edge E+1.
- o_busy: registered. High from the edge a word is accepted until the edge at which the FSM returns to IDLE with the FIFO empty.
- Frame length: (1+DATA_WIDTH+P+S)*(prescaler+1) clocks, where P is 0/1 and S is 1/2.
- o_uart_tx is driven from a flop; no combinational path from any input.

Optional Feature:
Macro UART_TX_CTS_EN.
- Defined: adds input port i_cts_n (1 bit, active-low clear-to-send, synchronised internally through 2 flops). The FSM starts a new frame (from IDLE or at the end of STOP) only while the synchronised CTS is low. A frame already started always completes. While CTS is high the line idles high, the FIFO keeps accepting writes, and o_busy stays high while the FIFO is non-empty.
- Not defined: no i_cts_n port; frames start unconditionally.

Test Plan:
- DATA_WIDTH=8, prescaler=3, parity none, 1 stop, push 0xA5 -> line low at E+1, then bits 1,0,1,0,0,1,0,1 and stop 1, each 4 clocks; 40 clocks total; o_busy falls at the frame end.
- 0xA5 with i_parity=10 -> parity bit 0; with i_parity=01 -> parity bit 1; i_two_stop=1 -> 8 clocks high before the next start or idle (frame 48 clocks).
- FIFO_DEPTH=4, prescaler=3, strobe words 0..5 on 6 consecutive cycles -> words 0..4 accepted, o_ready low from after cycle 4, o_fifo_level=4, word 5 dropped. The 5 frames are sent back-to-back (200 clocks, no idle gap) in order 0..4.
- Prescaler=0 -> each bit 1 clock, 10-clock frame. Change prescaler to 7 mid-frame -> current frame unaffected, next frame 80 clocks.
- Assert i_reset during data bit 3 with 2 words queued -> o_uart_tx=1, o_busy=0, level=0 immediately (before the next edge). No further frames after release.
- UART_TX_CTS_EN: hold i_cts_n=1, push 0x3C -> line stays high, o_busy=1. Drop i_cts_n -> start bit within 3 clocks. Raise i_cts_n mid-frame -> frame completes.
